// File: rtl/bp_me_mem_responder.sv
// Single-outstanding memory responder behind a CCE memory port.
// Block storage with cached/uncached access and fixed response latency.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_bp_inv_cfg
  } bp_params_e;

  localparam int bp_inv_paddr_width_gp = 40;
  localparam int bp_inv_block_width_gp = 512;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    logic [3:0]                       msg_type;
    logic [bp_inv_paddr_width_gp-1:0] addr;
    logic [2:0]                       size;
    logic [7:0]                       payload;
    logic [bp_inv_block_width_gp-1:0] data;
  } bp_cce_mem_msg_s;

  function automatic int bp_block_width(bp_params_e cfg);
    if (cfg == e_bp_inv_cfg) return bp_inv_block_width_gp;
    else return bp_inv_block_width_gp;
  endfunction

endpackage

module bp_me_mem_responder
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int mem_els_p = 64,
  parameter int mem_latency_p = 4,
  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_ready_i
);

  localparam int bw_lp = bp_block_width(bp_params_p);
  localparam int bytes_lp = bw_lp / 8;
  localparam int off_lp = $clog2(bytes_lp);
  localparam int idx_w_lp =
    (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int cnt_w_lp =
    (mem_latency_p > 0) ? $clog2(mem_latency_p + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  bp_cce_mem_msg_s     cmd_q, cmd_d;
  logic [bw_lp-1:0]    rdata_q, rdata_d;

  logic [bw_lp-1:0]    mem_q [mem_els_p];

  bp_cce_mem_msg_s     cmd_in;
  bp_cce_mem_msg_s     resp_s;
  logic                accept;
  logic                enter_resp;

  logic [2:0]          sz_c;
  logic [off_lp:0]     nbytes;
  logic [off_lp:0]     nb_m1;
  logic [off_lp-1:0]   boff;
  logic [idx_w_lp-1:0] idx;
  logic [bytes_lp-1:0] byte_mask;
  logic [bw_lp-1:0]    lo_mask;
  logic [bw_lp-1:0]    wdata_sh;
  logic [bw_lp-1:0]    rd_blk;

  assign cmd_in = mem_cmd_i;
  assign accept = mem_cmd_v_i & reset_n_i
                & (state_q == S_IDLE);
  assign mem_cmd_yumi_o = accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = cmd_in;
          cnt_d   = cnt_w_lp'(mem_latency_p);
          state_d = (mem_latency_p == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - cnt_w_lp'(1);
        if (cnt_q == cnt_w_lp'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Geometry follows cmd_d: the new command on accept, else the held one.
  always_comb begin
    sz_c = (cmd_d.size > 3'(off_lp)) ? 3'(off_lp) : cmd_d.size;
    nbytes = (off_lp+1)'(1) << sz_c;
    nb_m1 = nbytes - (off_lp+1)'(1);
    boff = cmd_d.addr[off_lp-1:0] & ~nb_m1[off_lp-1:0];
    idx = cmd_d.addr[off_lp +: idx_w_lp];
    byte_mask = ~({bytes_lp{1'b1}} << nbytes) << boff;
    lo_mask = ~({bw_lp{1'b1}} << {nbytes, 3'b000});
    wdata_sh = cmd_d.data << {boff, 3'b000};
    rd_blk = mem_q[idx];
  end

  assign enter_resp = (state_q != S_RESP)
                    && (state_d == S_RESP);

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      case (cmd_d.msg_type)
        e_cce_mem_rd:    rdata_d = rd_blk;
        e_cce_mem_uc_rd: rdata_d = (rd_blk >> {boff, 3'b000}) & lo_mask;
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      case (cmd_d.msg_type)
        e_cce_mem_wr: mem_q[idx] <= cmd_d.data;
        e_cce_mem_uc_wr: begin
          for (int b = 0; b < bytes_lp; b++) begin
            if (byte_mask[b])
              mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_s = '0;
    if (state_q == S_RESP) begin
      resp_s      = cmd_q;
      resp_s.data = rdata_q;
    end
  end

  assign mem_resp_o   = resp_s;
  assign mem_resp_v_o = (state_q == S_RESP);

endmodule

// File: tb/tb_bp_me_mem_responder.sv
// Directed bench for bp_me_mem_responder: vector table plus
// backpressure, reset and zero-latency sequences.
module tb_bp_me_mem_responder;
  import bp_me_pkg::*;

  localparam int W = $bits(bp_cce_mem_msg_s);
  localparam int CW = 1024;
  localparam int NV = 14;

  typedef struct {
    logic [3:0]   mt;
    logic [39:0]  a;
    logic [2:0]   sz;
    logic [511:0] d;
    logic [511:0] e;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] cmd;
  logic         cmd_v;
  logic         yumi;
  logic [W-1:0] resp;
  logic         resp_v;
  logic         rdy;

  logic [W-1:0] z_cmd;
  logic         z_v;
  logic         z_yumi;
  logic [W-1:0] z_resp;
  logic         z_resp_v;
  logic         z_rdy;

  int   n_tests;
  int   n_fail;
  int   acc_wait;
  vec_t vt [NV];

  bp_me_mem_responder #(
    .bp_params_p(e_bp_inv_cfg),
    .mem_els_p(64),
    .mem_latency_p(4)
  ) u_dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .mem_cmd_i(cmd),
    .mem_cmd_v_i(cmd_v),
    .mem_cmd_yumi_o(yumi),
    .mem_resp_o(resp),
    .mem_resp_v_o(resp_v),
    .mem_resp_ready_i(rdy)
  );

  bp_me_mem_responder #(
    .bp_params_p(e_bp_inv_cfg),
    .mem_els_p(64),
    .mem_latency_p(0)
  ) u_z (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .mem_cmd_i(z_cmd),
    .mem_cmd_v_i(z_v),
    .mem_cmd_yumi_o(z_yumi),
    .mem_resp_o(z_resp),
    .mem_resp_v_o(z_resp_v),
    .mem_resp_ready_i(z_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic bp_cce_mem_msg_s mk(
    input logic [3:0] mt, input logic [39:0] a,
    input logic [2:0] sz, input logic [7:0] pl,
    input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m.msg_type = mt;
    m.addr     = a;
    m.size     = sz;
    m.payload  = pl;
    m.data     = d;
    return m;
  endfunction

  task automatic chk(input string nm,
                     input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] mt,
                      input logic [39:0] a, input logic [2:0] sz,
                      input logic [511:0] d, input logic [511:0] e);
    vt[i].mt = mt;
    vt[i].a  = a;
    vt[i].sz = sz;
    vt[i].d  = d;
    vt[i].e  = e;
  endtask

  task automatic wait_acc(output int w, output bit seen);
    seen = 0;
    w = 0;
    while (!seen && w < 20) begin
      @(negedge clk);
      if (yumi) seen = 1;
      else w++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_resp(output int w, output bit seen);
    seen = 0;
    w = 0;
    while (!seen && w < 20) begin
      @(negedge clk);
      w++;
      if (resp_v) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_txn(input bp_cce_mem_msg_s m,
                        input logic [511:0] exp,
                        input string nm);
    bp_cce_mem_msg_s e;
    int  w;
    bit  seen;
    cmd   = m;
    cmd_v = 1'b1;
    rdy   = 1'b1;
    wait_acc(w, seen);
    cmd_v = 1'b0;
    acc_wait = w;
    chk({nm, " accept"}, CW'(seen), CW'(1));
    if (seen) begin
      wait_resp(w, seen);
      chk({nm, " latency"}, CW'(w), CW'(5));
      e = m;
      e.data = exp;
      chk({nm, " resp"}, CW'(resp), CW'(e));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bp_cce_mem_msg_s m, e;
    bp_cce_mem_msg_s zq [3];
    logic [511:0]    ze [3];
    int  w, zk, cnt_v;
    bit  seen;

    n_tests = 0;
    n_fail  = 0;

    setv(0,  e_cce_mem_wr, 40'h80000040, 3'd6,
         {64{8'hA5}}, '0);
    setv(1,  e_cce_mem_rd, 40'h80000040, 3'd6,
         '0, {64{8'hA5}});
    setv(2,  e_cce_mem_rd, 40'h80001040, 3'd6,
         '0, {64{8'hA5}});
    setv(3,  e_cce_mem_wr, 40'h80000040, 3'd6,
         '0, '0);
    setv(4,  e_cce_mem_uc_wr, 40'h80000044, 3'd2,
         512'hDEADBEEF, '0);
    setv(5,  e_cce_mem_uc_rd, 40'h80000040, 3'd3,
         '0, 512'hDEADBEEF_00000000);
    setv(6,  e_cce_mem_uc_rd, 40'h80000046, 3'd0,
         '0, 512'hAD);
    setv(7,  e_cce_mem_uc_rd, 40'h80000047, 3'd1,
         '0, 512'hDEAD);
    setv(8,  e_cce_mem_wr, 40'h80000080, 3'd6,
         {16{32'h01234567}}, '0);
    setv(9,  e_cce_mem_uc_rd, 40'h80000091, 3'd6,
         '0, {16{32'h01234567}});
    setv(10, 4'hF, 40'h80000080, 3'd6,
         {64{8'hFF}}, '0);
    setv(11, e_cce_mem_rd, 40'h80000080, 3'd6,
         '0, {16{32'h01234567}});
    setv(12, e_cce_mem_uc_wr, 40'h80000083, 3'd0,
         {{63{8'hFF}}, 8'h5A}, '0);
    setv(13, e_cce_mem_rd, 40'h80000080, 3'd6,
         '0, {{15{32'h01234567}}, 32'h5A234567});

    rst_n = 1'b0;
    cmd   = mk(vt[0].mt, vt[0].a, vt[0].sz, 8'd1, vt[0].d);
    cmd_v = 1'b1;
    rdy   = 1'b1;
    z_cmd = cmd;
    z_v   = 1'b1;
    z_rdy = 1'b1;

    #12;
    chk("reset yumi", CW'(yumi), CW'(0));
    chk("reset resp_v", CW'(resp_v), CW'(0));
    chk("reset resp", CW'(resp), CW'(0));
    chk("reset z_yumi", CW'(z_yumi), CW'(0));
    chk("reset z_resp_v", CW'(z_resp_v), CW'(0));
    z_v = 1'b0;

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      m = mk(vt[i].mt, vt[i].a, vt[i].sz, 8'(i + 1), vt[i].d);
      do_txn(m, vt[i].e, $sformatf("vec%0d", i));
      if (i == 0) chk("first accept", CW'(acc_wait), CW'(0));
    end

    // zero latency: accept, respond, accept ... with ready high
    zq[0] = mk(e_cce_mem_wr, 40'h80000080, 3'd6, 8'h70,
               {64{8'h77}});
    zq[1] = mk(e_cce_mem_rd, 40'h80000080, 3'd6, 8'h71, '0);
    zq[2] = mk(e_cce_mem_uc_rd, 40'h80000082, 3'd1, 8'h72, '0);
    ze[0] = '0;
    ze[1] = {64{8'h77}};
    ze[2] = 512'h7777;
    z_cmd = zq[0];
    z_v   = 1'b1;
    z_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      zk = i / 2;
      chk($sformatf("z%0d yumi", i), CW'(z_yumi),
          CW'((i % 2) == 0));
      chk($sformatf("z%0d resp_v", i), CW'(z_resp_v),
          CW'((i % 2) == 1));
      if ((i % 2) == 1) begin
        e = zq[zk];
        e.data = ze[zk];
        chk($sformatf("z%0d resp", i), CW'(z_resp), CW'(e));
      end
      @(posedge clk);
      #1;
      if ((i % 2) == 0) begin
        if (zk + 1 < 3) z_cmd = zq[zk + 1];
        else z_v = 1'b0;
      end
    end

    // backpressure with a second command waiting
    m = mk(e_cce_mem_rd, 40'h80000040, 3'd6, 8'h42, '0);
    e = m;
    e.data = 512'hDEADBEEF_00000000;
    cmd   = m;
    cmd_v = 1'b1;
    rdy   = 1'b0;
    wait_acc(w, seen);
    chk("bp accept", CW'(seen), CW'(1));
    cmd = mk(e_cce_mem_wr, 40'h80000100, 3'd6, 8'h43,
             {64{8'h11}});
    wait_resp(w, seen);
    chk("bp latency", CW'(w), CW'(5));
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp hold%0d", i), CW'({resp_v, yumi, resp}),
          CW'({1'b1, 1'b0, e}));
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    rdy = 1'b1;
    chk("bp last hold", CW'({resp_v, resp}), CW'({1'b1, e}));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp next accept", CW'({resp_v, yumi}), CW'({1'b0, 1'b1}));
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
    wait_resp(w, seen);
    e = cmd;
    e.data = '0;
    chk("bp next resp", CW'({seen, resp}), CW'({1'b1, e}));
    @(posedge clk);
    #1;

    // reset in WAIT after a write: response dropped, data kept
    cmd = mk(e_cce_mem_wr, 40'h800000C0, 3'd6, 8'h50,
             {64{8'h3C}});
    cmd_v = 1'b1;
    wait_acc(w, seen);
    chk("rstw accept", CW'(seen), CW'(1));
    cmd_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cmd_v = 1'b1;
    #1;
    chk("rstw outputs", CW'({yumi, resp_v, resp}), CW'(0));
    @(negedge clk);
    cmd_v = 1'b0;
    rst_n = 1'b1;
    cnt_v = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_v) cnt_v++;
    end
    chk("rstw no resp", CW'(cnt_v), CW'(0));
    @(posedge clk);
    #1;
    do_txn(mk(e_cce_mem_rd, 40'h800000C0, 3'd6, 8'h51, '0),
           {64{8'h3C}}, "rstw keep");

    // reset while a response is held: valid drops at once
    cmd   = mk(e_cce_mem_rd, 40'h80000080, 3'd6, 8'h60, '0);
    cmd_v = 1'b1;
    rdy   = 1'b0;
    wait_acc(w, seen);
    cmd_v = 1'b0;
    wait_resp(w, seen);
    chk("rstr resp_v", CW'(seen), CW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstr outputs", CW'({resp_v, resp}), CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b1;
    cnt_v = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_v) cnt_v++;
    end
    chk("rstr no resp", CW'(cnt_v), CW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_me_mem_responder.md
BP_ME_MEM_RESPONDER -- requirements
Module: bp_me_mem_responder

Interface
REQ-001 The block SHALL take parameter bp_params_p, default e_bp_inv_cfg, selecting the processor configuration (paddr_width_p, cce_block_width_p, cce_mem_msg_width_lp).
REQ-002 The block SHALL take parameter mem_els_p, default 64, the number of cce_block_width_p-bit storage blocks.
REQ-003 The block SHALL take parameter mem_latency_p, default 4, the number of wait cycles between command accept and response valid.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n_i  input  1  reset; asynchronous, active-low.
REQ-006 mem_cmd_i  input  cce_mem_msg_width_lp  bp_cce_mem_msg_s command: header msg_type, addr, size, payload; data.
REQ-007 mem_cmd_v_i  input  1  command valid.
REQ-008 mem_cmd_yumi_o  output  1  command consumed this cycle.
REQ-009 mem_resp_o  output  cce_mem_msg_width_lp  bp_cce_mem_msg_s response.
REQ-010 mem_resp_v_o  output  1  response valid.
REQ-011 mem_resp_ready_i  input  1  downstream can take the response.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT and RESP, with exactly one command outstanding at a time.
REQ-013 mem_cmd_yumi_o SHALL equal mem_cmd_v_i AND (state == IDLE), and SHALL be combinational with no dependence on mem_resp_ready_i.
REQ-014 On accept, the block SHALL register the command header and data, load the latency counter with mem_latency_p, and go to WAIT; if mem_latency_p == 0 it SHALL go directly to RESP.
REQ-015 In WAIT the counter SHALL decrement once per cycle, and the FSM SHALL go to RESP on the cycle the counter reaches 1.
REQ-016 mem_resp_v_o SHALL first assert exactly mem_latency_p+1 cycles after the accept cycle, and SHALL stay asserted with mem_resp_o stable until mem_resp_ready_i is high.
REQ-017 When mem_resp_v_o and mem_resp_ready_i are both high, the FSM SHALL return to IDLE; no command is accepted in that same cycle.
REQ-018 Block index SHALL be addr[block_offset +: clog2(mem_els_p)], where block_offset = clog2(cce_block_width_p/8); higher address bits SHALL be ignored, so addresses wrap modulo mem_els_p blocks.
REQ-019 e_cce_mem_wr SHALL write the full data block to the indexed entry on the accept edge.
REQ-020 e_cce_mem_uc_wr SHALL write only 2^size bytes, taken from data[0 +: 2^size bytes], at byte offset addr[block_offset-1:0] aligned down to the size; all other bytes SHALL be unchanged.
REQ-021 e_cce_mem_rd SHALL return the full indexed block; the read SHALL be taken on the WAIT->RESP transition, so an earlier write to the same address is always visible.
REQ-022 e_cce_mem_uc_rd SHALL return the 2^size addressed bytes right-justified in data, with all upper bits zero.
REQ-023 The response header SHALL echo the command msg_type, addr, size and payload unchanged.
REQ-024 For write responses, response data SHALL be all zero.
REQ-025 Any other msg_type SHALL be acknowledged as for a write, with zero data and storage unmodified.
REQ-026 Storage SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-027 While reset_n_i is low, the state SHALL be IDLE, the counter and registered command SHALL be zero, and mem_cmd_yumi_o, mem_resp_v_o and mem_resp_o SHALL be 0, independent of clk_i.
REQ-028 Reset asserted in WAIT or RESP SHALL abandon the outstanding command with no response issued; a write already applied at accept SHALL remain in storage.
REQ-029 After reset_n_i deasserts, the first command SHALL be accepted on the first clock edge with mem_cmd_v_i high.

Verification
REQ-030 Latency: with mem_latency_p=4, e_cce_mem_wr accepted at cycle 10 -> mem_resp_v_o first high at cycle 15, zero data, header echoed.
REQ-031 Block round trip: e_cce_mem_wr addr 0x80000040 with data pattern 0xA5.. -> a following e_cce_mem_rd at 0x80000040 returns 0xA5..; mem_els_p=64 with 64-byte blocks: a read at 0x80001040 returns the same data (wrap).
REQ-032 Uncached: e_cce_mem_uc_wr size=2 (4 bytes) addr 0x80000044 data 0xDEADBEEF over a block of zeros -> e_cce_mem_uc_rd size=3 addr 0x80000040 returns 0xDEADBEEF_00000000.
REQ-033 Backpressure: hold mem_resp_ready_i low for 7 cycles in RESP -> mem_resp_v_o stays high and mem_resp_o is stable; mem_cmd_yumi_o stays 0 with mem_cmd_v_i high; the next command is accepted the cycle after the handshake.
REQ-034 Reset mid-WAIT: assert reset_n_i low two cycles after a read is accepted -> outputs go to 0 asynchronously, and no response appears after release.
REQ-035 Zero latency: with mem_latency_p=0 and mem_resp_ready_i held high -> back-to-back commands are accepted every 2 cycles, with each response valid the cycle after its accept.
